// File: rtl/collatz_pkg.sv
// Shared definitions for the Collatz seed sweep: controller states and the
// default parameter values used by collatz_sweep and collatz_step.
package collatz_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STEP,
        COMPARE,
        FINISH
    } state_e;

    localparam int DEF_BITS      = 32;
    localparam int DEF_LEN_BITS  = 16;
    localparam int DEF_CNT_BITS  = 16;
    localparam int DEF_MAX_STEPS = 1000;

endpackage

// File: rtl/collatz_step.sv
// One combinational Collatz step: n/2 for even n, 3n+1 for odd n. The odd
// branch is evaluated two bits wider so an iterate that leaves BITS is flagged.
module collatz_step
    import collatz_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic [BITS-1:0] n_i,
    output logic [BITS-1:0] next_o,
    output logic            ovf_o
);

    logic [BITS+1:0] tripled;

    always_comb begin
        tripled = {2'b00, n_i} + {1'b0, n_i, 1'b0} + (BITS+2)'(1);
        if (n_i[0]) begin
            next_o = tripled[BITS-1:0];
            ovf_o  = |tripled[BITS+1:BITS];
        end else begin
            next_o = {1'b0, n_i[BITS-1:1]};
            ovf_o  = 1'b0;
        end
    end

endmodule

// File: rtl/collatz_sweep.sv
// Sweeps seed_count consecutive seeds from seed_base, one Collatz step per
// cycle, and reports the seed with the longest orbit that reached 1.
module collatz_sweep
    import collatz_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int LEN_BITS  = DEF_LEN_BITS,
    parameter int CNT_BITS  = DEF_CNT_BITS,
    parameter int MAX_STEPS = DEF_MAX_STEPS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [BITS-1:0]     seed_base_i,
    input  logic [CNT_BITS-1:0] seed_count_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [BITS-1:0]     best_seed_o,
    output logic [LEN_BITS-1:0] best_orbit_len_o,
    output logic [BITS-1:0]     best_path_record_o,
    output logic                overflow_o,
    output logic                limit_hit_o
);

    state_e              state_q;
    logic [BITS-1:0]     seed_q;
    logic [CNT_BITS-1:0] remain_q;
    logic [BITS-1:0]     iter_q;
    logic [LEN_BITS-1:0] len_q;
    logic [BITS-1:0]     rec_q;
    logic                abort_q;
    logic [BITS-1:0]     best_seed_q;
    logic [LEN_BITS-1:0] best_len_q;
    logic [BITS-1:0]     best_rec_q;
    logic                ovf_q;
    logic                lim_q;
    logic                busy_q;
    logic                done_q;

    logic [BITS-1:0]     step_next;
    logic                step_ovf;
    logic [LEN_BITS-1:0] len_d;
    logic [CNT_BITS-1:0] remain_d;
    logic [BITS-1:0]     seed_d;
    logic [BITS-1:0]     rec_d;
    logic                reached_one;
    logic                at_cap;
    logic                improves;

    collatz_step #(
        .BITS (BITS)
    ) u_step (
        .n_i    (iter_q),
        .next_o (step_next),
        .ovf_o  (step_ovf)
    );

    always_comb begin
        len_d       = len_q + LEN_BITS'(1);
        remain_d    = remain_q - CNT_BITS'(1);
        seed_d      = seed_q + BITS'(1);
        rec_d       = (step_next > rec_q) ? step_next : rec_q;
        reached_one = (step_next == BITS'(1));
        at_cap      = (len_d == LEN_BITS'(MAX_STEPS));
        // Strictly greater keeps the earliest seed on ties.
        improves    = !abort_q && (len_q > best_len_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            seed_q      <= '0;
            remain_q    <= '0;
            iter_q      <= '0;
            len_q       <= '0;
            rec_q       <= '0;
            abort_q     <= 1'b0;
            best_seed_q <= '0;
            best_len_q  <= '0;
            best_rec_q  <= '0;
            ovf_q       <= 1'b0;
            lim_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        seed_q      <= seed_base_i;
                        remain_q    <= seed_count_i;
                        best_seed_q <= '0;
                        best_len_q  <= '0;
                        best_rec_q  <= '0;
                        ovf_q       <= 1'b0;
                        lim_q       <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LOAD;
                    end
                end
                LOAD: begin
                    iter_q  <= seed_q;
                    len_q   <= '0;
                    rec_q   <= seed_q;
                    abort_q <= 1'b0;
                    if (remain_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else if (seed_q <= BITS'(1)) begin
                        state_q <= COMPARE;
                    end else begin
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    if (step_ovf) begin
                        abort_q <= 1'b1;
                        ovf_q   <= 1'b1;
                        state_q <= COMPARE;
                    end else begin
                        iter_q <= step_next;
                        len_q  <= len_d;
                        rec_q  <= rec_d;
                        // Reaching 1 on the capped step still counts as complete.
                        if (reached_one) begin
                            state_q <= COMPARE;
                        end else if (at_cap) begin
                            abort_q <= 1'b1;
                            lim_q   <= 1'b1;
                            state_q <= COMPARE;
                        end
                    end
                end
                COMPARE: begin
                    if (improves) begin
                        best_seed_q <= seed_q;
                        best_len_q  <= len_q;
                        best_rec_q  <= rec_q;
                    end
                    remain_q <= remain_d;
                    seed_q   <= seed_d;
                    if (remain_d == '0 || seed_d == '0) begin
                        if (remain_d != '0) begin
                            ovf_q <= 1'b1;
                        end
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        state_q <= LOAD;
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign best_seed_o        = best_seed_q;
    assign best_orbit_len_o   = best_len_q;
    assign best_path_record_o = best_rec_q;
    assign overflow_o         = ovf_q;
    assign limit_hit_o        = lim_q;

endmodule

// File: tb/tb_collatz_sweep.sv
// Bench for collatz_sweep: three instances (default, BITS=8, MAX_STEPS=16)
// driven from a vector table plus model-generated sweeps and corner sequences.
module tb_collatz_sweep;

    typedef struct {
        int unsigned sel;
        logic [31:0] base;
        logic [15:0] cnt;
        logic [31:0] seed;
        logic [15:0] len;
        logic [31:0] rec;
        logic        ovf;
        logic        lim;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    int unsigned sel;
    logic [31:0] base;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;
    vec_t sb_q[$];

    always #5 clk = ~clk;

    logic        busy0, done0, ovf0, lim0;
    logic [31:0] bs0, br0;
    logic [15:0] bl0;
    logic        busy1, done1, ovf1, lim1;
    logic [7:0]  bs1, br1, base8;
    logic [15:0] bl1;
    logic        busy2, done2, ovf2, lim2;
    logic [31:0] bs2, br2;
    logic [15:0] bl2;
    logic        st0, st1, st2;

    assign st0   = start && (sel == 0);
    assign st1   = start && (sel == 1);
    assign st2   = start && (sel == 2);
    assign base8 = base[7:0];

    collatz_sweep dut0 (
        .clk(clk), .reset(reset), .start_i(st0), .seed_base_i(base), .seed_count_i(cnt),
        .busy_o(busy0), .done_o(done0), .best_seed_o(bs0), .best_orbit_len_o(bl0),
        .best_path_record_o(br0), .overflow_o(ovf0), .limit_hit_o(lim0)
    );

    collatz_sweep #(.BITS(8)) dut1 (
        .clk(clk), .reset(reset), .start_i(st1), .seed_base_i(base8), .seed_count_i(cnt),
        .busy_o(busy1), .done_o(done1), .best_seed_o(bs1), .best_orbit_len_o(bl1),
        .best_path_record_o(br1), .overflow_o(ovf1), .limit_hit_o(lim1)
    );

    collatz_sweep #(.MAX_STEPS(16)) dut2 (
        .clk(clk), .reset(reset), .start_i(st2), .seed_base_i(base), .seed_count_i(cnt),
        .busy_o(busy2), .done_o(done2), .best_seed_o(bs2), .best_orbit_len_o(bl2),
        .best_path_record_o(br2), .overflow_o(ovf2), .limit_hit_o(lim2)
    );

    logic        o_busy, o_done, o_ovf, o_lim;
    logic [31:0] o_seed, o_rec;
    logic [15:0] o_len;

    always_comb begin
        o_busy = busy0; o_done = done0; o_seed = bs0; o_len = bl0;
        o_rec  = br0;   o_ovf  = ovf0;  o_lim  = lim0;
        if (sel == 1) begin
            o_busy = busy1; o_done = done1; o_seed = {24'd0, bs1}; o_len = bl1;
            o_rec  = {24'd0, br1}; o_ovf = ovf1; o_lim = lim1;
        end else if (sel == 2) begin
            o_busy = busy2; o_done = done2; o_seed = bs2; o_len = bl2;
            o_rec  = br2;   o_ovf  = ovf2;  o_lim  = lim2;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int unsigned s, input logic [31:0] b, input logic [15:0] c,
                                input logic [31:0] sd, input logic [15:0] ln, input logic [31:0] rc,
                                input logic ov, input logic lm);
        vec_t v;
        v.sel = s; v.base = b; v.cnt = c; v.seed = sd; v.len = ln; v.rec = rc; v.ovf = ov; v.lim = lm;
        return v;
    endfunction

    // Reference: walk every seed with 64-bit arithmetic and explicit bounds.
    function automatic vec_t model(input int unsigned s, input logic [31:0] b, input logic [15:0] c);
        vec_t r;
        longint unsigned top, n, t, sd, ln, rc;
        int maxs;
        bit ab;
        top  = (s == 1) ? 64'd256 : 64'h1_0000_0000;
        maxs = (s == 2) ? 16 : 1000;
        r = mk(s, b, c, 0, 0, 0, 0, 0);
        for (int k = 0; k < int'(c); k++) begin
            sd = 64'(b) + 64'(k);
            if (sd >= top) begin r.ovf = 1'b1; break; end
            n = sd; ln = 0; rc = sd; ab = 1'b0;
            while (n > 1) begin
                if (n[0]) begin
                    t = 3 * n + 1;
                    if (t >= top) begin r.ovf = 1'b1; ab = 1'b1; break; end
                end else begin
                    t = n >> 1;
                end
                ln++;
                if (t > rc) rc = t;
                n = t;
                if (n == 1) break;
                if (ln == 64'(maxs)) begin r.lim = 1'b1; ab = 1'b1; break; end
            end
            if (!ab && ln > 64'(r.len)) begin
                r.seed = sd[31:0]; r.len = ln[15:0]; r.rec = rc[31:0];
            end
        end
        return r;
    endfunction

    task automatic compare_result(input vec_t e, input string tag);
        check({tag, "_seed"}, o_seed, e.seed);
        check({tag, "_len"}, {16'd0, o_len}, {16'd0, e.len});
        check({tag, "_rec"}, o_rec, e.rec);
        check({tag, "_ovf"}, {31'd0, o_ovf}, {31'd0, e.ovf});
        check({tag, "_lim"}, {31'd0, o_lim}, {31'd0, e.lim});
    endtask

    // Starts a sweep, optionally pokes start mid-sweep, waits for done and
    // scores the popped expectation. cyc = negedges from the accepting edge.
    task automatic run_sweep(input vec_t v, input bit chained, input bit poke, input string tag,
                             output int cyc);
        vec_t e;
        bit got;
        if (!chained) @(negedge clk);
        sel = v.sel; base = v.base; cnt = v.cnt; start = 1'b1;
        sb_q.push_back(v);
        @(posedge clk); #1;
        if (chained) begin
            check({tag, "_busy_in_finish"}, {31'd0, o_busy}, 32'd0);
            @(posedge clk); #1;
        end
        start = 1'b0;
        got = 1'b0;
        cyc = 0;
        for (int i = 1; i <= 20000; i++) begin
            @(negedge clk);
            if (i == 1) check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
            if (poke && i == 5) begin base = 32'd27; cnt = 16'd1; start = 1'b1; end
            if (poke && i == 6) begin start = 1'b0; base = v.base; cnt = v.cnt; end
            if (o_done) begin cyc = i; got = 1'b1; break; end
        end
        e = sb_q.pop_front();
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no done expected done", tag);
        end else begin
            check({tag, "_busy_at_done"}, {31'd0, o_busy}, 32'd0);
            compare_result(e, tag);
        end
    endtask

    vec_t tbl[8];
    vec_t rv;
    int   cyc;
    int   done_seen;

    initial begin
        tbl[0] = mk(0, 27, 1, 27, 111, 9232, 0, 0);
        tbl[1] = mk(0, 1, 10, 9, 19, 52, 0, 0);
        tbl[2] = mk(0, 12, 2, 12, 9, 16, 0, 0);
        tbl[3] = mk(1, 27, 1, 0, 0, 0, 1, 0);
        tbl[4] = mk(2, 27, 1, 0, 0, 0, 0, 1);
        tbl[5] = mk(2, 6, 2, 7, 16, 52, 0, 0);
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[7] = mk(0, 3, 4, 6, 8, 16, 0, 0);

        reset = 1'b1; start = 1'b0; sel = 0; base = '0; cnt = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check($sformatf("reset%0d_busy", s), {31'd0, o_busy}, 32'd0);
            check($sformatf("reset%0d_done", s), {31'd0, o_done}, 32'd0);
            compare_result(mk(s, 0, 0, 0, 0, 0, 0, 0), $sformatf("reset%0d", s));
        end

        for (int i = 0; i < 8; i++) begin
            run_sweep(tbl[i], 1'b0, 1'b0, $sformatf("vec%0d", i), cyc);
            if (i == 0) begin
                check("vec0_latency", cyc, 114);
                @(negedge clk);
                check("vec0_done_pulse", {31'd0, o_done}, 32'd0);
                repeat (4) @(negedge clk);
                compare_result(tbl[0], "vec0_hold");
            end
            if (i == 6) check("count0_latency", cyc, 2);
        end

        run_sweep(tbl[1], 1'b0, 1'b1, "poke", cyc);
        run_sweep(tbl[2], 1'b1, 1'b0, "chain", cyc);

        run_sweep(model(1, 250, 10), 1'b0, 1'b0, "wrap8", cyc);
        for (int k = 0; k < 8; k++) begin
            rv = model($urandom_range(0, 2), 32'($urandom_range(0, 255)), 16'($urandom_range(0, 12)));
            run_sweep(rv, 1'b0, 1'b0, $sformatf("rnd%0d", k), cyc);
        end

        @(negedge clk);
        sel = 0; base = 32'd1; cnt = 16'd10; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (60) @(negedge clk);
        check("prereset_busy", {31'd0, o_busy}, 32'd1);
        check("prereset_len", {16'd0, o_len}, 32'd16);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", {31'd0, o_busy}, 32'd0);
        compare_result(mk(0, 0, 0, 0, 0, 0, 0, 0), "midreset");
        done_seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (o_done) done_seen++;
        end
        check("midreset_no_done", done_seen, 0);
        run_sweep(tbl[0], 1'b0, 1'b0, "after_reset", cyc);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
